// File: rtl/div_pkg.sv
// Shared types for the divider result buffer: tag-FIFO and result-FIFO entries.
package div_pkg;

    localparam int DIV_LATENCY = 64;
    localparam int DIV_WIDTH   = 64;
    localparam int DIV_TAG_W   = 8;

    typedef struct packed {
        logic [DIV_TAG_W-1:0] tag;
        logic                 div0;
    } div_tag_entry_t;

    typedef struct packed {
        logic [DIV_WIDTH-1:0] quotient;
        logic [DIV_WIDTH-1:0] remainder;
        logic [DIV_TAG_W-1:0] tag;
        logic                 div0;
    } div_res_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra-MSB pointers; pushes when full and pops when
// empty are ignored, and the head is presented without fall-through.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign count   = wr_ptr - rd_ptr;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage is left unreset; consumers gate the head with their own valid.
    always_ff @(posedge clk_in) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/div_result_buffer.sv
// Credit-gated result buffer behind the fixed-latency divider; tags and div0 flags
// ride a side FIFO. Define DIV_RESULT_PROTOCOL_CHECK_EN to build the sticky error flag.
module div_result_buffer
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,  // must match div_pkg entry widths
    parameter int TAG_W = DIV_TAG_W,
    parameter int DEPTH = 128
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    output logic             issue_ready_out,
    input  logic             issue_fire_in,
    input  logic [TAG_W-1:0] issue_tag_in,
    input  logic [WIDTH-1:0] issue_divisor_in,
    input  logic             div_valid_in,
    input  logic [WIDTH-1:0] div_quotient_in,
    input  logic [WIDTH-1:0] div_remainder_in,
    output logic             res_valid_out,
    input  logic             res_ready_in,
    output logic [WIDTH-1:0] res_quotient_out,
    output logic [WIDTH-1:0] res_remainder_out,
    output logic [TAG_W-1:0] res_tag_out,
    output logic             res_div0_out,
    output logic             protocol_err_out
);

    localparam int AW = $clog2(DEPTH);

    div_tag_entry_t tag_din, tag_dout;
    div_res_entry_t res_din, res_dout;
    logic           tag_full, tag_empty, res_full, res_empty;
    logic [AW:0]    tag_count, res_count;
    logic [AW+1:0]  outstanding;
    logic           tag_push, tag_pop, res_push, res_pop;

    // Credit only looks at registered counts, so a pop frees a slot one cycle later.
    assign outstanding     = {1'b0, tag_count} + {1'b0, res_count};
    assign issue_ready_out = rst_n_in && (outstanding < (AW+2)'(DEPTH));

    assign tag_push = issue_fire_in && issue_ready_out && !tag_full;
    assign tag_pop  = div_valid_in && !tag_empty;
    assign res_push = div_valid_in && !res_full;
    assign res_pop  = res_valid_out && res_ready_in;

    always_comb begin
        tag_din          = '0;
        tag_din.tag      = issue_tag_in;
        tag_din.div0     = (issue_divisor_in == '0);
        res_din          = '0;
        res_din.quotient = div_quotient_in;
        res_din.remainder = div_remainder_in;
        // An orphan result (no outstanding tag) is kept with tag 0 / div0 0.
        res_din.tag      = tag_empty ? '0 : tag_dout.tag;
        res_din.div0     = tag_empty ? 1'b0 : tag_dout.div0;
    end

    sync_fifo #(
        .WIDTH ($bits(div_tag_entry_t)),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push     (tag_push),
        .pop      (tag_pop),
        .din      (tag_din),
        .dout     (tag_dout),
        .full     (tag_full),
        .empty    (tag_empty),
        .count    (tag_count)
    );

    sync_fifo #(
        .WIDTH ($bits(div_res_entry_t)),
        .DEPTH (DEPTH)
    ) u_res_fifo (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .push     (res_push),
        .pop      (res_pop),
        .din      (res_din),
        .dout     (res_dout),
        .full     (res_full),
        .empty    (res_empty),
        .count    (res_count)
    );

    assign res_valid_out     = !res_empty;
    assign res_quotient_out  = res_valid_out ? res_dout.quotient  : '0;
    assign res_remainder_out = res_valid_out ? res_dout.remainder : '0;
    assign res_tag_out       = res_valid_out ? res_dout.tag       : '0;
    assign res_div0_out      = res_valid_out && res_dout.div0;

`ifdef DIV_RESULT_PROTOCOL_CHECK_EN
    logic err_q;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            err_q <= 1'b0;
        end else if ((issue_fire_in && !issue_ready_out) ||
                     (div_valid_in && tag_empty) ||
                     (div_valid_in && res_full)) begin
            err_q <= 1'b1;
        end
    end

    assign protocol_err_out = err_q;
`else
    assign protocol_err_out = 1'b0;
`endif

endmodule

// File: tb/tb_div_result_buffer.sv
// Directed bench for div_result_buffer with a 64-stage behavioural divider in front.
module tb_div_result_buffer;
    import div_pkg::*;

    localparam int WIDTH = 64;
    localparam int TAG_W = 8;
    localparam int DEPTH = 128;
    localparam int LAT   = DIV_LATENCY;
`ifdef DIV_RESULT_PROTOCOL_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic             clk_in, rst_n_in;
    logic             issue_ready_out, issue_fire_in;
    logic [TAG_W-1:0] issue_tag_in;
    logic [WIDTH-1:0] issue_divisor_in;
    logic             div_valid_in;
    logic [WIDTH-1:0] div_quotient_in, div_remainder_in;
    logic             res_valid_out, res_ready_in;
    logic [WIDTH-1:0] res_quotient_out, res_remainder_out;
    logic [TAG_W-1:0] res_tag_out;
    logic             res_div0_out, protocol_err_out;

    div_result_buffer #(.WIDTH(WIDTH), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .issue_ready_out   (issue_ready_out),
        .issue_fire_in     (issue_fire_in),
        .issue_tag_in      (issue_tag_in),
        .issue_divisor_in  (issue_divisor_in),
        .div_valid_in      (div_valid_in),
        .div_quotient_in   (div_quotient_in),
        .div_remainder_in  (div_remainder_in),
        .res_valid_out     (res_valid_out),
        .res_ready_in      (res_ready_in),
        .res_quotient_out  (res_quotient_out),
        .res_remainder_out (res_remainder_out),
        .res_tag_out       (res_tag_out),
        .res_div0_out      (res_div0_out),
        .protocol_err_out  (protocol_err_out)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Behavioural divider: fixed latency, in order, reset with the buffer.
    logic [WIDTH-1:0] dividend;
    logic             m_v [LAT];
    logic [WIDTH-1:0] m_q [LAT];
    logic [WIDTH-1:0] m_r [LAT];
    logic             inj_v;
    logic [WIDTH-1:0] inj_q, inj_r;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < LAT; i++) m_v[i] <= 1'b0;
        end else begin
            m_v[0] <= issue_fire_in;
            m_q[0] <= (issue_divisor_in == '0) ? '1 : dividend / issue_divisor_in;
            m_r[0] <= (issue_divisor_in == '0) ? dividend : dividend % issue_divisor_in;
            for (int i = 1; i < LAT; i++) begin
                m_v[i] <= m_v[i-1];
                m_q[i] <= m_q[i-1];
                m_r[i] <= m_r[i-1];
            end
        end
    end

    assign div_valid_in     = m_v[LAT-1] | inj_v;
    assign div_quotient_in  = inj_v ? inj_q : m_q[LAT-1];
    assign div_remainder_in = inj_v ? inj_r : m_r[LAT-1];

    typedef struct {
        logic [TAG_W-1:0] tag;
        logic [WIDTH-1:0] q;
        logic [WIDTH-1:0] r;
        logic             d0;
    } exp_t;
    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    // Drives one request and records its expected result when credit is present.
    task automatic fire(input logic [TAG_W-1:0] tag, input logic [WIDTH-1:0] dvd,
                        input logic [WIDTH-1:0] dvs);
        exp_t e;
        issue_fire_in    = 1'b1;
        issue_tag_in     = tag;
        dividend         = dvd;
        issue_divisor_in = dvs;
        if (issue_ready_out) begin
            e.tag = tag;
            e.d0  = (dvs == 0);
            e.q   = (dvs == 0) ? {WIDTH{1'b1}} : dvd / dvs;
            e.r   = (dvs == 0) ? dvd : dvd % dvs;
            exp_q.push_back(e);
        end
    endtask

    task automatic idle();
        issue_fire_in    = 1'b0;
        issue_tag_in     = '0;
        issue_divisor_in = '0;
        dividend         = '0;
    endtask

    task automatic test_reset();
        rst_n_in = 1'b0;
        #1;
        n_checks++;
        if (issue_ready_out !== 1'b0 || res_valid_out !== 1'b0) begin
            $display("FAIL reset_ctl: ready=%b valid=%b required 0/0", issue_ready_out, res_valid_out);
            n_fail++;
        end
        n_checks++;
        if (res_quotient_out !== '0 || res_remainder_out !== '0 || res_tag_out !== '0 ||
            res_div0_out !== 1'b0 || protocol_err_out !== 1'b0) begin
            $display("FAIL reset_data: q=%h r=%h tag=%h d0=%b err=%b required all 0",
                     res_quotient_out, res_remainder_out, res_tag_out, res_div0_out, protocol_err_out);
            n_fail++;
        end
        repeat (3) tick();
        rst_n_in = 1'b1;
        #1;
        n_checks++;
        if (issue_ready_out !== 1'b1) begin
            $display("FAIL reset_release_ready: got %b required 1", issue_ready_out);
            n_fail++;
        end
        tick();
        n_checks++;
        if (res_valid_out !== 1'b0) begin
            $display("FAIL reset_release_valid: got %b required 0", res_valid_out);
            n_fail++;
        end
    endtask

    task automatic single(input string name, input logic [TAG_W-1:0] tag,
                          input logic [WIDTH-1:0] dvd, input logic [WIDTH-1:0] dvs,
                          input logic [WIDTH-1:0] eq, input logic [WIDTH-1:0] er,
                          input logic ed0);
        fire(tag, dvd, dvs);
        tick();
        idle();
        repeat (LAT-1) tick();
        n_checks++;
        if (res_valid_out !== 1'b0) begin
            $display("FAIL %s_early: valid=%b required 0 one cycle before", name, res_valid_out);
            n_fail++;
        end
        tick();
        n_checks++;
        if (res_valid_out !== 1'b1 || res_quotient_out !== eq || res_remainder_out !== er ||
            res_tag_out !== tag || res_div0_out !== ed0) begin
            $display("FAIL %s: v=%b q=%h r=%h tag=%h d0=%b required 1 %h %h %h %b", name,
                     res_valid_out, res_quotient_out, res_remainder_out, res_tag_out, res_div0_out,
                     eq, er, tag, ed0);
            n_fail++;
        end
        void'(exp_q.pop_front());
        res_ready_in = 1'b1;
        tick();
        res_ready_in = 1'b0;
        n_checks++;
        if (res_valid_out !== 1'b0) begin
            $display("FAIL %s_drain: valid=%b required 0", name, res_valid_out);
            n_fail++;
        end
    endtask

    task automatic test_single();
        single("single", 8'h5A, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0);
    endtask

    task automatic test_div0();
        single("div0", 8'h03, 64'd9, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd9, 1'b1);
    endtask

    task automatic test_back_to_back();
        int sent = 0;
        int got  = 0;
        res_ready_in = 1'b1;
        for (int cyc = 0; cyc < 600 && got < 200; cyc++) begin
            if (res_valid_out) begin
                n_checks++;
                if (res_tag_out !== exp_q[0].tag || res_quotient_out !== exp_q[0].q ||
                    res_remainder_out !== exp_q[0].r || res_div0_out !== exp_q[0].d0) begin
                    $display("FAIL b2b_data #%0d: tag=%h q=%h r=%h d0=%b required %h %h %h %b", got,
                             res_tag_out, res_quotient_out, res_remainder_out, res_div0_out,
                             exp_q[0].tag, exp_q[0].q, exp_q[0].r, exp_q[0].d0);
                    n_fail++;
                end
                void'(exp_q.pop_front());
                got++;
            end
            if (sent < 200) begin
                n_checks++;
                if (issue_ready_out !== 1'b1) begin
                    $display("FAIL b2b_stall at fire %0d: ready=%b required 1", sent, issue_ready_out);
                    n_fail++;
                end
                fire(TAG_W'(sent), 64'(sent * 37 + 5), 64'(sent % 9));
                sent++;
            end else begin
                idle();
            end
            tick();
        end
        res_ready_in = 1'b0;
        idle();
        n_checks++;
        if (got != 200) begin
            $display("FAIL b2b_count: got %0d results required 200", got);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        int fired = 0;
        res_ready_in = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (!issue_ready_out) break;
            fire(TAG_W'(fired), 64'(1000 + fired), 64'(fired % 5 + 1));
            fired++;
            tick();
        end
        idle();
        n_checks++;
        if (fired != DEPTH) begin
            $display("FAIL bp_fires: got %0d fires before credit stall required %0d", fired, DEPTH);
            n_fail++;
        end
        repeat (LAT + 6) tick();
        n_checks++;
        if (issue_ready_out !== 1'b0 || res_valid_out !== 1'b1) begin
            $display("FAIL bp_full: ready=%b valid=%b required 0/1", issue_ready_out, res_valid_out);
            n_fail++;
        end
        for (int k = 0; k < DEPTH; k++) begin
            n_checks++;
            if (res_valid_out !== 1'b1 || res_tag_out !== exp_q[0].tag ||
                res_quotient_out !== exp_q[0].q || res_remainder_out !== exp_q[0].r) begin
                $display("FAIL bp_data #%0d: v=%b tag=%h q=%h r=%h required 1 %h %h %h", k,
                         res_valid_out, res_tag_out, res_quotient_out, res_remainder_out,
                         exp_q[0].tag, exp_q[0].q, exp_q[0].r);
                n_fail++;
            end
            void'(exp_q.pop_front());
            res_ready_in = 1'b1;
            tick();
            n_checks++;
            if (issue_ready_out !== 1'b1) begin
                $display("FAIL bp_credit after pop %0d: ready=%b required 1", k, issue_ready_out);
                n_fail++;
            end
        end
        res_ready_in = 1'b0;
        n_checks++;
        if (res_valid_out !== 1'b0) begin
            $display("FAIL bp_empty: valid=%b required 0", res_valid_out);
            n_fail++;
        end
    endtask

    task automatic test_simultaneous();
        res_ready_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            fire(TAG_W'(8'h20 + i), 64'(50 + i), 64'd3);
            tick();
        end
        idle();
        repeat (LAT + 6) tick();
        for (int i = 0; i < 5; i++) begin
            fire(TAG_W'(8'h30 + i), 64'(80 + i), 64'd6);
            tick();
        end
        idle();
        repeat (LAT - 5) tick();
        // Next edge: fire, divider result and pop all land with 5 in flight / 5 buffered.
        n_checks++;
        if (res_valid_out !== 1'b1 || res_tag_out !== 8'h20) begin
            $display("FAIL sim_head: v=%b tag=%h required 1 20", res_valid_out, res_tag_out);
            n_fail++;
        end
        void'(exp_q.pop_front());
        fire(8'h40, 64'd77, 64'd10);
        res_ready_in = 1'b1;
        tick();
        idle();
        res_ready_in = 1'b0;
        n_checks++;
        if (res_tag_out !== 8'h21 || issue_ready_out !== 1'b1) begin
            $display("FAIL sim_after: tag=%h ready=%b required 21 1", res_tag_out, issue_ready_out);
            n_fail++;
        end
        res_ready_in = 1'b1;
        for (int cyc = 0; cyc < 200 && exp_q.size() > 0; cyc++) begin
            if (res_valid_out) begin
                n_checks++;
                if (res_tag_out !== exp_q[0].tag || res_quotient_out !== exp_q[0].q ||
                    res_remainder_out !== exp_q[0].r) begin
                    $display("FAIL sim_drain: tag=%h q=%h r=%h required %h %h %h", res_tag_out,
                             res_quotient_out, res_remainder_out, exp_q[0].tag, exp_q[0].q, exp_q[0].r);
                    n_fail++;
                end
                void'(exp_q.pop_front());
            end
            tick();
        end
        res_ready_in = 1'b0;
        n_checks++;
        if (exp_q.size() != 0 || res_valid_out !== 1'b0) begin
            $display("FAIL sim_done: %0d results missing, valid=%b required 0/0", exp_q.size(), res_valid_out);
            n_fail++;
        end
    endtask

    task automatic test_orphan();
        inj_v = 1'b1;
        inj_q = 64'h1234;
        inj_r = 64'h56;
        tick();
        inj_v = 1'b0;
        n_checks++;
        if (res_valid_out !== 1'b1 || res_tag_out !== 8'h00 || res_div0_out !== 1'b0 ||
            res_quotient_out !== 64'h1234 || res_remainder_out !== 64'h56) begin
            $display("FAIL orphan_data: v=%b tag=%h d0=%b q=%h r=%h required 1 00 0 1234 56",
                     res_valid_out, res_tag_out, res_div0_out, res_quotient_out, res_remainder_out);
            n_fail++;
        end
        n_checks++;
        if (protocol_err_out !== EXP_ERR) begin
            $display("FAIL orphan_err: got %b required %b", protocol_err_out, EXP_ERR);
            n_fail++;
        end
        res_ready_in = 1'b1;
        tick();
        res_ready_in = 1'b0;
        repeat (5) tick();
        n_checks++;
        if (protocol_err_out !== EXP_ERR || res_valid_out !== 1'b0) begin
            $display("FAIL orphan_sticky: err=%b valid=%b required %b 0", protocol_err_out,
                     res_valid_out, EXP_ERR);
            n_fail++;
        end
    endtask

    task automatic test_reset_midstream();
        res_ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            fire(TAG_W'(8'h70 + i), 64'(500 + i), 64'd4);
            tick();
        end
        idle();
        repeat (LAT + 2) tick();
        fire(8'h77, 64'd99, 64'd2);
        tick();
        idle();
        #2;
        rst_n_in = 1'b0;
        #1;
        n_checks++;
        if (res_valid_out !== 1'b0 || res_quotient_out !== '0 || res_remainder_out !== '0 ||
            res_tag_out !== '0 || issue_ready_out !== 1'b0 || protocol_err_out !== 1'b0) begin
            $display("FAIL midreset: v=%b q=%h r=%h tag=%h rdy=%b err=%b required all 0",
                     res_valid_out, res_quotient_out, res_remainder_out, res_tag_out,
                     issue_ready_out, protocol_err_out);
            n_fail++;
        end
        exp_q.delete();
        tick();
        rst_n_in = 1'b1;
        #1;
        n_checks++;
        if (issue_ready_out !== 1'b1) begin
            $display("FAIL midreset_ready: got %b required 1", issue_ready_out);
            n_fail++;
        end
        repeat (LAT + 4) tick();
        n_checks++;
        if (res_valid_out !== 1'b0 || protocol_err_out !== 1'b0) begin
            $display("FAIL midreset_flushed: valid=%b err=%b required 0/0", res_valid_out, protocol_err_out);
            n_fail++;
        end
    endtask

    initial begin
        rst_n_in     = 1'b0;
        res_ready_in = 1'b0;
        inj_v        = 1'b0;
        inj_q        = '0;
        inj_r        = '0;
        idle();
        test_reset();
        test_single();
        test_div0();
        test_back_to_back();
        test_backpressure();
        test_simultaneous();
        test_orphan();
        test_reset_midstream();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div_result_buffer.md
Name: div_result_buffer

Overview:
- Downstream companion of the 64-stage pipelined divider (fixed latency, no backpressure, no tag, no divide-by-zero flag).
- Gives upstream a credit so the divider is only fired when a result slot is guaranteed.
- Carries request tags and divide-by-zero flags alongside the pipeline.
- Buffers results into a FIFO drained by a valid/ready consumer.

Parameters:
- WIDTH, 64, quotient/remainder width; matches divider.
- TAG_W, 8, request tag width.
- DEPTH, 128, max outstanding requests (in flight plus buffered); power of 2; must exceed the divider latency (64) for full throughput.

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- issue_ready_out  output  1  credit available; upstream may fire the divider this cycle
- issue_fire_in  input  1  upstream fired the divider this cycle (same cycle as divider data_valid_in)
- issue_tag_in  input  TAG_W  tag of the fired request
- issue_divisor_in  input  WIDTH  divisor of the fired request (for zero detection)
- div_valid_in  input  1  divider data_valid_out
- div_quotient_in  input  WIDTH  divider quotient_out
- div_remainder_in  input  WIDTH  divider remainder_out
- res_valid_out  output  1  result available
- res_ready_in  input  1  consumer accepts
- res_quotient_out  output  WIDTH  quotient
- res_remainder_out  output  WIDTH  remainder
- res_tag_out  output  TAG_W  tag of the result
- res_div0_out  output  1  divisor was zero; quotient/remainder are the raw divider output
- protocol_err_out  output  1  sticky protocol violation (see Optional Feature)

Behaviour:
- Reset (async assert, sync deassert expected upstream):
  - both FIFOs empty, counters 0.
  - issue_ready_out=1 once reset is released; held 0 while rst_n_in low.
  - res_valid_out=0, protocol_err_out=0, data outputs 0.
- Tag FIFO (depth DEPTH, entry {tag, div0}):
  - push on issue_fire_in; div0 = (issue_divisor_in==0).
  - pop on div_valid_in.
  - Order holds because the divider is in-order with fixed latency.
- Result FIFO (depth DEPTH, entry {quotient, remainder, tag, div0}):
  - push on div_valid_in, using the tag-FIFO head as tag/div0.
  - pop on res_valid_out && res_ready_in.
- Credit:
  - outstanding = tag_count + res_count.
  - issue_ready_out = (outstanding < DEPTH), computed from registered counts only.
  - A same-cycle result pop frees credit the next cycle (conservative, no combinational path from res_ready_in).
- Counter update with simultaneous events:
  - tag_count += fire − div_valid.
  - res_count += div_valid − pop.
  - Every combination of fire, div_valid and pop in the same cycle must be handled.
- Result FIFO pushed and popped in the same cycle while empty: no fall-through; the push lands and res_valid_out rises next cycle. Push-to-valid latency is 1 cycle.
- Result outputs:
  - driven from the result-FIFO head; stable while res_valid_out && !res_ready_in.
  - res_valid_out = (res_count != 0).
- Divide-by-zero: divider output is passed through unchanged (quotient all ones, remainder = dividend); the only change is res_div0_out=1.
- issue_fire_in while issue_ready_out=0 is illegal. Push is dropped; handling per Optional Feature.
- div_valid_in with tag FIFO empty is illegal. The result is still pushed if space exists, with tag 0 and div0 0.
- Reset mid-operation discards all buffered and in-flight state. The divider pipeline must be reset in the same domain, or its late results are flagged as orphans.
- Pointers: log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ and low bits equal.

Optional Feature:
- Macro: DIV_RESULT_PROTOCOL_CHECK_EN.
- With the macro: protocol_err_out sets on any of the following and clears only on reset:
  - fire without credit
  - div_valid_in with tag FIFO empty
  - result push with result FIFO full
- Without the macro: protocol_err_out is tied 0 and no check logic is built. Illegal stimulus behaviour is otherwise identical.

Decomposition:
- Package div_pkg:
  - div_tag_entry_t {tag, div0}.
  - div_res_entry_t {quotient, remainder, tag, div0}.
  - DIV_LATENCY=64 constant.
- One sub-module, sync_fifo, with parameters WIDTH/DEPTH, ports push/pop/full/empty/count. It is instantiated twice: the tag FIFO and the result FIFO.

Test Plan:
- Single request: fire with tag 0x5A, divisor 7, dividend 100; divider returns q=14, r=2 64 cycles later -> one cycle after that, res_valid_out=1 with q=14, r=2, tag 0x5A, div0=0.
- Divisor 0: fire with tag 0x03, dividend 9 -> result q=0xFFFF_FFFF_FFFF_FFFF, r=9, div0=1.
- Back-to-back: 200 fires with tags 0..199 mod 256 and res_ready_in held 1 -> every result in order, no credit stall after the first 64 cycles.
- Backpressure: res_ready_in=0 and fire every cycle -> issue_ready_out drops after exactly 128 fires, no result lost; release ready -> all 128 drained in order and credit returns one cycle after each pop.
- Simultaneous fire + div_valid + pop with counts 5/5 -> counts stay 5/5 and data order is preserved.
- With DIV_RESULT_PROTOCOL_CHECK_EN, inject div_valid_in with no prior fire -> protocol_err_out=1 next cycle and sticky until rst_n_in low; asynchronous reset asserted mid-stream clears all outputs immediately.
